// File: rtl/lsu_bus_master.sv
// Load/store initiator: one word-aligned AR/R or AW+W/B transaction per request, result held until resp_ready.
// Latency: accept->resp_valid 3 cycles on a zero-wait slave, 1 cycle for exceptions; req_ready is high only in IDLE.
module lsu_bus_master #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wen,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_exc,
  output logic [3:0]    resp_cause,
  output logic [AW-1:0] resp_tval,
  output logic [AW-1:0] m_araddr,
  output logic          m_arvalid,
  input  logic          m_arready,
  input  logic [DW-1:0] m_rdata,
  input  logic [1:0]    m_rresp,
  input  logic          m_rvalid,
  output logic          m_rready,
  output logic [AW-1:0] m_awaddr,
  output logic          m_awvalid,
  input  logic          m_awready,
  output logic [DW-1:0] m_wdata,
  output logic [3:0]    m_wstrb,
  output logic          m_wvalid,
  input  logic          m_wready,
  input  logic [1:0]    m_bresp,
  input  logic          m_bvalid,
  output logic          m_bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;

  state_t        state;
  logic [2:0]    f3_q;
  logic [AW-1:0] addr_q;
  logic          aw_done;
  logic          w_done;

  logic          illegal;
  logic          misal;
  logic [AW-1:0] aligned_addr;
  logic [4:0]    st_shamt;
  logic [3:0]    store_strb;
  logic [DW-1:0] store_wdata;
  logic [4:0]    ld_shamt;
  logic [DW-1:0] rshift;
  logic [DW-1:0] load_val;
  logic          aw_now;
  logic          w_now;

  // Request classification and store lane placement, evaluated on the incoming request
  always_comb begin
    illegal = 1'b0;
    if (req_wen)
      illegal = (req_funct3 != 3'b000) && (req_funct3 != 3'b001) && (req_funct3 != 3'b010);
    else
      illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    aligned_addr = {req_addr[AW-1:2], 2'b00};
    st_shamt     = {req_addr[1:0], 3'b000};
    store_wdata  = req_wdata << st_shamt;
    case (req_funct3[1:0])
      2'b00:   store_strb = 4'b0001 << req_addr[1:0];
      2'b01:   store_strb = 4'b0011 << req_addr[1:0];
      default: store_strb = 4'b1111;
    endcase
  end

  // Load byte-lane alignment and extension from the latched funct3/offset
  always_comb begin
    ld_shamt = {addr_q[1:0], 3'b000};
    rshift   = m_rdata >> ld_shamt;
    case (f3_q)
      3'b000:  load_val = {{(DW-8){rshift[7]}}, rshift[7:0]};
      3'b001:  load_val = {{(DW-16){rshift[15]}}, rshift[15:0]};
      3'b100:  load_val = {{(DW-8){1'b0}}, rshift[7:0]};
      3'b101:  load_val = {{(DW-16){1'b0}}, rshift[15:0]};
      default: load_val = rshift;
    endcase
  end

  assign aw_now = aw_done | (m_awvalid & m_awready);
  assign w_now  = w_done  | (m_wvalid & m_wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_exc   <= 1'b0;
      resp_cause <= 4'd0;
      resp_tval  <= '0;
      m_araddr   <= '0;
      m_arvalid  <= 1'b0;
      m_rready   <= 1'b0;
      m_awaddr   <= '0;
      m_awvalid  <= 1'b0;
      m_wdata    <= '0;
      m_wstrb    <= 4'b0000;
      m_wvalid   <= 1'b0;
      m_bready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            f3_q       <= req_funct3;
            addr_q     <= req_addr;
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            resp_exc   <= 1'b0;
            resp_cause <= 4'd0;
            resp_tval  <= '0;
            if (illegal) begin
              resp_exc   <= 1'b1;
              resp_cause <= 4'd2;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (misal) begin
              resp_exc   <= 1'b1;
              resp_cause <= req_wen ? 4'd6 : 4'd4;
              resp_tval  <= req_addr;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (req_wen) begin
              m_awaddr  <= aligned_addr;
              m_wdata   <= store_wdata;
              m_wstrb   <= store_strb;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
              state     <= WR_REQ;
            end else begin
              m_araddr  <= aligned_addr;
              m_arvalid <= 1'b1;
              state     <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_rvalid) begin
            m_rready   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
            if (m_rresp != 2'b00) begin
              resp_exc   <= 1'b1;
              resp_cause <= 4'd5;
              resp_tval  <= addr_q;
            end else begin
              resp_rdata <= load_val;
            end
          end
        end
        WR_REQ: begin
          // AW and W complete independently; each valid drops right after its own handshake
          if (m_awvalid && m_awready) m_awvalid <= 1'b0;
          if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
          if (aw_now && w_now) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            m_bready <= 1'b1;
            state    <= WR_RESP;
          end else begin
            aw_done <= aw_now;
            w_done  <= w_now;
          end
        end
        WR_RESP: begin
          if (m_bvalid) begin
            m_bready   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
            if (m_bresp != 2'b00) begin
              resp_exc   <= 1'b1;
              resp_cause <= 4'd7;
              resp_tval  <= addr_q;
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store unit initiator between the EXU and the data-memory slave.
- Accepts one load/store per handshake from the EXU, checks funct3 and alignment, and issues one word-aligned AXI-lite-style transaction: AR/R for loads, AW+W/B for stores.
- Returns the byte-lane-shifted, sign- or zero-extended load data, or an exception cause, to the writeback side.
- Unlike the existing combinational DPI memory, this drives a multi-cycle bus slave with ready/valid handshakes.

Parameters:
- AW, 32, address width.
- DW, 32, data width (fixed at 32; `RegBus`).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  EXU has a memory op.
- req_ready  out  1  LSU can accept (high only in IDLE).
- req_wen  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3 of the load/store.
- req_addr  in  AW  effective byte address.
- req_wdata  in  DW  store data (rs2).
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_rdata  out  DW  extended load data (0 for stores and exceptions).
- resp_exc  out  1  exception flag.
- resp_cause  out  4  mcause code when resp_exc = 1.
- resp_tval  out  AW  faulting address when resp_exc = 1, else 0.
- m_araddr  out  AW  read address.
- m_arvalid  out  1  read address valid.
- m_arready  in  1  read address ready.
- m_rdata  in  DW  read data.
- m_rresp  in  2  read response (0 = OKAY).
- m_rvalid  in  1  read data valid.
- m_rready  out  1  read data ready.
- m_awaddr  out  AW  write address.
- m_awvalid  out  1  write address valid.
- m_awready  in  1  write address ready.
- m_wdata  out  DW  write data.
- m_wstrb  out  4  byte strobes.
- m_wvalid  out  1  write data valid.
- m_wready  in  1  write data ready.
- m_bresp  in  2  write response.
- m_bvalid  in  1  write response valid.
- m_bready  out  1  write response ready.

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- Reset (rst = 1 at posedge) forces IDLE from any state, including mid-transaction. On reset:
  - all m_*valid, m_rready, m_bready, resp_valid = 0; req_ready = 1.
  - resp_rdata, resp_cause, resp_tval, m_* addr/data/strb = 0.
  - An abandoned bus transaction is not completed; the slave shares rst.
- IDLE: on req_valid & req_ready, latch wen, funct3, addr, wdata. Classify the request:
  - Illegal funct3 (load: 011, 110, 111; store: anything but 000/001/010): cause 2, tval = 0, go to RESP. No bus traffic.
  - Misaligned (H with addr[0] = 1; W with addr[1:0] != 0): cause 4 for a load, 6 for a store; tval = addr; go to RESP. No bus traffic.
  - Otherwise go to RD_ADDR (load) or WR_REQ (store).
- RD_ADDR:
  - m_arvalid = 1, m_araddr = {addr[AW-1:2], 2'b00}, both stable until m_arready.
  - On m_arready go to RD_DATA.
- RD_DATA:
  - m_rready = 1. On m_rvalid, shift m_rdata right by 8*addr[1:0].
  - Extend: LB/LH sign-extend, LBU/LHU zero-extend, LW pass through.
  - m_rresp != 0: resp_exc = 1, cause 5, tval = addr, rdata = 0.
  - Go to RESP.
- WR_REQ:
  - m_awvalid and m_wvalid asserted together; m_awaddr is word-aligned.
  - m_wstrb: SB = 0001 << addr[1:0], SH = 0011 << addr[1:0], SW = 1111.
  - m_wdata = wdata << 8*addr[1:0].
  - AW and W may handshake in different cycles. Track aw_done and w_done; each valid drops the cycle after its own handshake.
  - Go to WR_RESP when both are done, including the same-cycle case.
- WR_RESP:
  - m_bready = 1. On m_bvalid go to RESP.
  - m_bresp != 0: resp_exc = 1, cause 7, tval = addr.
- RESP:
  - resp_valid = 1 with registered resp_*; all fields stay stable until resp_ready.
  - On resp_ready go to IDLE. No new request is accepted in the same cycle; req_ready rises the next cycle.
- Minimum latency, load with a zero-wait slave:
  - Accept at cycle 0; arvalid cycle 1; rvalid cycle 2; resp_valid cycle 3.
  - Store with zero-wait slave: resp_valid at cycle 3.
  - Exception (no bus traffic): resp_valid at cycle 1.
- Only one outstanding transaction. m_rready/m_bready are never high outside their own states.
- Widths:
  - Shift amounts are 5-bit (8*addr[1:0]).
  - Extension replicates bit 7 or bit 15 of the shifted word.

Test Plan:
- LB at 0x80000003, slave m_rdata = 0x80FF1234, zero-wait → m_araddr = 0x80000000; resp_rdata = 0xFFFFFF80; resp_valid at cycle 3; resp_exc = 0.
- LHU at 0x80000002, m_rdata = 0xBEEF0000 → resp_rdata = 0x0000BEEF. Same read with LH → resp_rdata = 0xFFFFBEEF.
- SH at 0x80000002, wdata = 0x1234ABCD:
  - m_awaddr = 0x80000000, m_wstrb = 1100, m_wdata = 0xABCD0000.
  - m_awready held low 3 cycles while m_wready = 1: m_wvalid drops after 1 cycle, m_awvalid stays until its handshake, then bready phase, then resp_valid.
- LW at 0x80000006 → resp_valid at cycle 1, resp_exc = 1, cause = 4, tval = 0x80000006, no m_arvalid ever.
- SW at 0x80000001 → cause = 6 with no bus traffic.
- Load funct3 = 111 → cause = 2 with no bus traffic.
- LW with m_rresp = 2 → cause 5, tval = addr.
- SW with m_bresp = 2 → cause 7, tval = addr.
- resp_ready held low 4 cycles → resp_* stable throughout.
- rst asserted in RD_DATA → next cycle IDLE, req_ready = 1, m_rready = 0, resp_valid = 0.
